parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 8: number of slots; entry is ineligible when car_count >= CAPACITY.
REQ-002 Parameter OPEN_CYCLES, default 3: cycles spent in OPENING; legal range 1..255.
REQ-003 Parameter CLOSE_CYCLES, default 3: cycles spent in CLOSING; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 20: maximum PASSING cycles without car_passed; legal range 1..255.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 entry_req  input  1  level; car waiting at entry lane.
REQ-008 exit_req  input  1  level; car waiting at exit lane.
REQ-009 car_count  input  4  current occupancy from the lot counter.
REQ-010 car_passed  input  1  one-cycle sensor pulse; car cleared the barrier.
REQ-011 gate_open  output  1  barrier raised; high only in PASSING.
REQ-012 entry_grant  output  1  entry lane owns the gate.
REQ-013 exit_grant  output  1  exit lane owns the gate.
REQ-014 inc_pulse  output  1  one-cycle increment request to the counter.
REQ-015 dec_pulse  output  1  one-cycle decrement request to the counter.
REQ-016 entry_denied  output  1  registered; entry_req present while lot is full.
REQ-017 busy  output  1  state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, OPENING, PASSING and CLOSING; all outputs SHALL be registered.
REQ-019 Eligibility: entry_ok = entry_req && car_count < CAPACITY; exit_ok = exit_req && car_count != 0.
REQ-020 In IDLE, an edge sampling exactly one eligible lane SHALL move the FSM to OPENING and assert that lane's grant from the next cycle.
REQ-021 Both eligible in IDLE: the lane not served last SHALL win, and last_served SHALL update on every grant.
REQ-022 Grant SHALL be one-hot and held through OPENING, PASSING and CLOSING, and SHALL deassert on return to IDLE.
REQ-023 OPENING SHALL last exactly OPEN_CYCLES cycles, then the FSM SHALL enter PASSING.
REQ-024 In PASSING, gate_open = 1; car_passed sampled high SHALL move the FSM to CLOSING, with inc_pulse (entry) or dec_pulse (exit) high for exactly the first CLOSING cycle.
REQ-025 PASSING SHALL last at most TIMEOUT_CYCLES cycles; on expiry the FSM SHALL enter CLOSING with no pulse.
REQ-026 CLOSING SHALL last exactly CLOSE_CYCLES cycles, then the FSM SHALL enter IDLE; at least one IDLE cycle SHALL separate transactions.
REQ-027 car_passed outside PASSING SHALL be ignored, and at most one pulse SHALL be issued per transaction.
REQ-028 Deassertion of the granted request after grant SHALL NOT abort the transaction.
REQ-029 car_count > CAPACITY SHALL be treated as full.
REQ-030 entry_denied SHALL equal the previous cycle's (entry_req && car_count >= CAPACITY), in any state.
REQ-031 Ineligible requests SHALL be ignored, not queued; re-evaluation SHALL occur every IDLE cycle.
REQ-032 Internal timer SHALL be 8 bits and SHALL be reloaded on every state entry.

Reset
REQ-033 reset high at an edge SHALL force IDLE, clear the timer, set last_served = exit (entry wins the first tie), and drive all outputs to 0 on the next cycle, including mid-transaction.
REQ-034 Grants SHALL NOT be issued in the cycle reset is sampled high.

Verification
REQ-035 Single entry (car_count=3): entry_req sampled at edge k -> entry_grant from k+1; gate_open from k+4; car_passed at edge m -> inc_pulse for one cycle at m+1; busy low at m+4.
REQ-036 Tie (car_count=4): entry_req and exit_req held after reset -> entry served first, then exit served, then entry served (alternation).
REQ-037 Full (car_count=8): entry_req held -> no entry_grant, entry_denied=1 from next cycle; exit_req then granted with dec_pulse on pass.
REQ-038 Empty (car_count=0): exit_req only -> no grant ever, busy stays 0.
REQ-039 Timeout: grant entry, no car_passed -> PASSING for 20 cycles, CLOSING for 3 cycles, no inc_pulse, then IDLE.
REQ-040 Reset in PASSING: gate_open=1, reset pulsed -> all outputs 0 the next cycle, and a subsequent tie is granted to entry.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : parking_gate_arbiter                                        |
// | Description : Single-barrier gate shared by entry and exit lanes, with    |
// |               fair tie-breaking, timed open/close phases and occupancy   |
// |               pulses to the lot counter.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module parking_gate_arbiter #(
   parameter int CAPACITY       = 8,
   parameter int OPEN_CYCLES    = 3,
   parameter int CLOSE_CYCLES   = 3,
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic [3:0] car_count,
   input  logic       car_passed,
   output logic       gate_open,
   output logic       entry_grant,
   output logic       exit_grant,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       entry_denied,
   output logic       busy
);

   localparam logic [7:0] c_open_load  = 8'(OPEN_CYCLES - 1);
   localparam logic [7:0] c_pass_load  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] c_close_load = 8'(CLOSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPENING = 2'd1,
      ST_PASSING = 2'd2,
      ST_CLOSING = 2'd3
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_timer, w_timer_nxt;
   logic       r_last_exit, w_last_exit_nxt;
   logic       r_entry_grant, w_entry_grant_nxt;
   logic       r_exit_grant, w_exit_grant_nxt;
   logic       w_inc_nxt, w_dec_nxt;
   logic       r_gate_open, r_inc_pulse, r_dec_pulse, r_entry_denied, r_busy;
   logic       w_room, w_entry_ok, w_exit_ok;

   // Counts above CAPACITY fall out of this compare as "full".
   assign w_room     = int'(car_count) < CAPACITY;
   assign w_entry_ok = entry_req && w_room;
   assign w_exit_ok  = exit_req && (car_count != 4'd0);

   always_comb begin
      w_state_nxt       = r_state;
      w_timer_nxt       = r_timer;
      w_last_exit_nxt   = r_last_exit;
      w_entry_grant_nxt = r_entry_grant;
      w_exit_grant_nxt  = r_exit_grant;
      w_inc_nxt         = 1'b0;
      w_dec_nxt         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer_nxt       = 8'd0;
            w_entry_grant_nxt = 1'b0;
            w_exit_grant_nxt  = 1'b0;
            // On a tie the lane not served last wins.
            if (w_entry_ok && (!w_exit_ok || r_last_exit)) begin
               w_state_nxt       = ST_OPENING;
               w_timer_nxt       = c_open_load;
               w_entry_grant_nxt = 1'b1;
               w_last_exit_nxt   = 1'b0;
            end else if (w_exit_ok) begin
               w_state_nxt       = ST_OPENING;
               w_timer_nxt       = c_open_load;
               w_exit_grant_nxt  = 1'b1;
               w_last_exit_nxt   = 1'b1;
            end
         end
         ST_OPENING: begin
            if (r_timer == 8'd0) begin
               w_state_nxt = ST_PASSING;
               w_timer_nxt = c_pass_load;
            end else begin
               w_timer_nxt = r_timer - 8'd1;
            end
         end
         ST_PASSING: begin
            if (car_passed) begin
               w_state_nxt = ST_CLOSING;
               w_timer_nxt = c_close_load;
               w_inc_nxt   = r_entry_grant;
               w_dec_nxt   = r_exit_grant;
            end else if (r_timer == 8'd0) begin
               w_state_nxt = ST_CLOSING;
               w_timer_nxt = c_close_load;
            end else begin
               w_timer_nxt = r_timer - 8'd1;
            end
         end
         ST_CLOSING: begin
            if (r_timer == 8'd0) begin
               w_state_nxt       = ST_IDLE;
               w_timer_nxt       = 8'd0;
               w_entry_grant_nxt = 1'b0;
               w_exit_grant_nxt  = 1'b0;
            end else begin
               w_timer_nxt = r_timer - 8'd1;
            end
         end
         default: begin
            w_state_nxt       = ST_IDLE;
            w_timer_nxt       = 8'd0;
            w_entry_grant_nxt = 1'b0;
            w_exit_grant_nxt  = 1'b0;
         end
      endcase
   end

   // Outputs are registered from the next-state values so they align with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_timer        <= 8'd0;
         r_last_exit    <= 1'b1;
         r_entry_grant  <= 1'b0;
         r_exit_grant   <= 1'b0;
         r_gate_open    <= 1'b0;
         r_inc_pulse    <= 1'b0;
         r_dec_pulse    <= 1'b0;
         r_entry_denied <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_timer        <= w_timer_nxt;
         r_last_exit    <= w_last_exit_nxt;
         r_entry_grant  <= w_entry_grant_nxt;
         r_exit_grant   <= w_exit_grant_nxt;
         r_gate_open    <= (w_state_nxt == ST_PASSING);
         r_inc_pulse    <= w_inc_nxt;
         r_dec_pulse    <= w_dec_nxt;
         r_entry_denied <= entry_req && !w_room;
         r_busy         <= (w_state_nxt != ST_IDLE);
      end
   end

   assign gate_open    = r_gate_open;
   assign entry_grant  = r_entry_grant;
   assign exit_grant   = r_exit_grant;
   assign inc_pulse    = r_inc_pulse;
   assign dec_pulse    = r_dec_pulse;
   assign entry_denied = r_entry_denied;
   assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_parking_gate_arbiter                                     |
// | Description : Random-stimulus scoreboard bench for parking_gate_arbiter.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_parking_gate_arbiter;

   localparam int CAP = 8;
   localparam int OC  = 3;
   localparam int CC  = 3;
   localparam int TO  = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_req;
   logic       exit_req;
   logic [3:0] car_count;
   logic       car_passed;
   logic       gate_open, entry_grant, exit_grant;
   logic       inc_pulse, dec_pulse, entry_denied, busy;

   always #5 clk = ~clk;

   parking_gate_arbiter #(
      .CAPACITY      (CAP),
      .OPEN_CYCLES   (OC),
      .CLOSE_CYCLES  (CC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .car_count   (car_count),
      .car_passed  (car_passed),
      .gate_open   (gate_open),
      .entry_grant (entry_grant),
      .exit_grant  (exit_grant),
      .inc_pulse   (inc_pulse),
      .dec_pulse   (dec_pulse),
      .entry_denied(entry_denied),
      .busy        (busy)
   );

   int         checks = 0;
   int         errors = 0;
   logic [6:0] exp_q[$];

   // Transaction-level reference: a transaction is described by the edge it
   // was granted on and the edge its passing phase ended on.
   int edge_n      = 0;
   bit m_active    = 1'b0;
   bit m_lane_exit = 1'b0;
   bit m_last_exit = 1'b1;
   bit m_closing   = 1'b0;
   bit m_denied    = 1'b0;
   int m_start     = 0;
   int m_close_at  = 0;

   task automatic model_step();
      logic [6:0] e;
      bit eok, xok, pulse_now;
      edge_n++;
      pulse_now = 1'b0;
      if (reset) begin
         m_active    = 1'b0;
         m_last_exit = 1'b1;
         m_denied    = 1'b0;
      end else begin
         eok      = entry_req && (int'(car_count) < CAP);
         xok      = exit_req && (car_count != 4'd0);
         m_denied = entry_req && (int'(car_count) >= CAP);
         if (m_active) begin
            if (!m_closing && (edge_n - 1 >= m_start + OC) && car_passed) begin
               m_closing  = 1'b1;
               m_close_at = edge_n;
               pulse_now  = 1'b1;
            end else if (!m_closing && edge_n == m_start + OC + TO) begin
               m_closing  = 1'b1;
               m_close_at = edge_n;
            end
            if (m_closing && edge_n == m_close_at + CC)
               m_active = 1'b0;
         end else if (eok || xok) begin
            m_lane_exit = !(eok && (!xok || m_last_exit));
            m_last_exit = m_lane_exit;
            m_active    = 1'b1;
            m_closing   = 1'b0;
            m_start     = edge_n;
         end
      end
      e = 7'd0;
      if (m_active) begin
         e[6] = !m_closing && (edge_n >= m_start + OC);
         e[5] = !m_lane_exit;
         e[4] = m_lane_exit;
         e[3] = pulse_now && !m_lane_exit;
         e[2] = pulse_now && m_lane_exit;
         e[0] = 1'b1;
      end
      e[1] = m_denied;
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: the DUT presents its registered outputs every cycle.
   initial begin
      logic [6:0] act, exp_v;
      forever begin
         @(posedge clk);
         #1;
         act = {gate_open, entry_grant, exit_grant, inc_pulse, dec_pulse, entry_denied, busy};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty edge=%0d actual=%b required=<entry>", edge_n, act);
         end else begin
            exp_v = exp_q.pop_front();
            if (act !== exp_v) begin
               errors++;
               $display("FAIL outputs{gate,eg,xg,inc,dec,den,busy} edge=%0d actual=%b required=%b",
                        edge_n, act, exp_v);
            end
         end
      end
   end

   task automatic drive(input int mode);
      reset = 1'b0;
      case (mode)
         0: begin
            entry_req  = 1'($urandom_range(0, 1));
            exit_req   = 1'($urandom_range(0, 1));
            car_count  = 4'($urandom_range(0, 15));
            car_passed = ($urandom_range(0, 3) == 0);
         end
         1: begin
            entry_req  = 1'b1;
            exit_req   = 1'b1;
            car_count  = 4'd4;
            car_passed = ($urandom_range(0, 7) == 0);
         end
         2: begin
            entry_req  = 1'b1;
            exit_req   = 1'($urandom_range(0, 1));
            car_count  = 4'($urandom_range(8, 15));
            car_passed = ($urandom_range(0, 4) == 0);
         end
         3: begin
            entry_req  = 1'b0;
            exit_req   = 1'b1;
            car_count  = 4'd0;
            car_passed = ($urandom_range(0, 2) == 0);
         end
         4: begin
            entry_req  = 1'($urandom_range(0, 1));
            exit_req   = 1'($urandom_range(0, 1));
            car_count  = 4'($urandom_range(1, 7));
            car_passed = 1'b0;
         end
         default: begin
            entry_req  = 1'($urandom_range(0, 1));
            exit_req   = 1'($urandom_range(0, 1));
            car_count  = 4'($urandom_range(3, 5));
            car_passed = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 19) == 0);
         end
      endcase
   endtask

   initial begin
      reset      = 1'b1;
      entry_req  = 1'b0;
      exit_req   = 1'b0;
      car_count  = 4'd0;
      car_passed = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int rep = 0; rep < 4; rep++) begin
         for (int mode = 0; mode < 6; mode++) begin
            for (int cyc = 0; cyc < 100; cyc++) begin
               @(negedge clk);
               drive(mode);
            end
         end
      end
      @(negedge clk);
      reset      = 1'b0;
      entry_req  = 1'b0;
      exit_req   = 1'b0;
      car_passed = 1'b0;
      repeat (40) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
